// File: rtl/ra4_mult.sv
// Sequential 4x4 unsigned multiplier: one shift-add step per cycle through a single 4-bit adder.
// Runs continuously in a 5-cycle frame (LOAD + four iterations) and publishes {Cout, Z} with a done pulse.
module ra4_mult (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [6:0] Z,
    output logic       Cout,
    output logic       done
);

    localparam logic [2:0] LAST_PHASE = 3'd4;

    logic [2:0] cnt;
    logic [3:0] m;
    logic [3:0] acc;
    logic [3:0] q;
    logic [4:0] sum;

    // The multiplicand is gated by q[0] in front of the adder, so only one adder is built.
    // NOTE: always_comb assigns sum on every path; a missing assignment would infer a latch.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, m & {4{q[0]}}};
    end

    // The carry bit of P is always cleared by the right shift, so sum[4] goes straight into
    // acc[3] and no separate carry flop is kept.
    // NOTE: every register, including the datapath, is cleared by the async reset so an aborted
    // iteration leaves nothing behind; all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 3'd0;
            m    <= 4'd0;
            acc  <= 4'd0;
            q    <= 4'd0;
            Z    <= 7'd0;
            Cout <= 1'b0;
            done <= 1'b0;
        end else if (cnt == 3'd0) begin
            m    <= A;
            q    <= B;
            acc  <= 4'd0;
            cnt  <= 3'd1;
            done <= 1'b0;
        end else begin
            acc <= sum[4:1];
            q   <= {sum[0], q[3:1]};
            if (cnt == LAST_PHASE) begin
                Cout <= sum[4];
                Z    <= {sum[3:0], q[3:1]};
                done <= 1'b1;
                cnt  <= 3'd0;
            end else begin
                cnt  <= cnt + 3'd1;
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ra4_mult.sv
// Self-checking bench for ra4_mult: spec vectors, exhaustive sweep, random pairs with
// mid-frame operand disturbance, done period, and reset abort.
module tb_ra4_mult;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [6:0] Z;
    logic       Cout;
    logic       done;

    int checks   = 0;
    int failures = 0;

    ra4_mult dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Z    (Z),
        .Cout (Cout),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cout;
        logic [6:0] z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance on falling edges until done is seen or the budget runs out; n = edges waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Called at a falling edge where done is high: the next rising edge is LOAD.
    task automatic run_pair(input string name, input logic [3:0] a, input logic [3:0] b,
                            input bit disturb);
        int n;
        int prod;
        A = a;
        B = b;
        prod = int'(a) * int'(b);
        if (disturb) begin
            @(negedge clk);
            A = 4'($urandom);
            B = 4'($urandom);
        end
        wait_done(n);
        check({name, "_product"}, {24'd0, Cout, Z}, prod);
    endtask

    initial begin
        vec_t vecs[9];
        int   n;

        vecs[0] = '{4'b1111, 4'b1110, 1'b1, 7'b1010010};
        vecs[1] = '{4'b1010, 4'b1011, 1'b0, 7'b1101110};
        vecs[2] = '{4'b1100, 4'b1101, 1'b1, 7'b0011100};
        vecs[3] = '{4'b0111, 4'b1000, 1'b0, 7'b0111000};
        vecs[4] = '{4'b1001, 4'b1010, 1'b0, 7'b1011010};
        vecs[5] = '{4'b0000, 4'b1001, 1'b0, 7'b0000000};
        vecs[6] = '{4'b0110, 4'b0000, 1'b0, 7'b0000000};
        vecs[7] = '{4'b1111, 4'b1111, 1'b1, 7'b1100001};
        vecs[8] = '{4'b0001, 4'b1111, 1'b0, 7'b0001111};

        rst_n = 1'b0;
        A = 4'd3;
        B = 4'd5;
        #23;
        check("reset_z", {25'd0, Z}, 32'd0);
        check("reset_cout", {31'd0, Cout}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // First product appears at the fifth rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(n);
        check("first_latency", n, 32'd5);
        check("first_product", {24'd0, Cout, Z}, 32'd15);

        // done period: low for four falling-edge samples, high on the fifth.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("period_done_%0d", i), {31'd0, done}, (i == 5) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            A = vecs[i].a;
            B = vecs[i].b;
            wait_done(n);
            check($sformatf("vec%0d_latency", i), n, 32'd5);
            check($sformatf("vec%0d_cout", i), {31'd0, Cout}, {31'd0, vecs[i].cout});
            check($sformatf("vec%0d_z", i), {25'd0, Z}, {25'd0, vecs[i].z});
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_pair($sformatf("sweep_%0d_%0d", a, b), 4'(a), 4'(b), 1'b0);
            end
        end

        // Random pairs; odd iterations scramble the operands after LOAD, which must be ignored.
        for (int i = 0; i < 40; i++) begin
            run_pair($sformatf("rand%0d", i), 4'($urandom), 4'($urandom), i[0]);
        end

        // Reset mid-iteration: outputs clear at once and the partial result never appears.
        A = 4'd15;
        B = 4'd15;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_z", {25'd0, Z}, 32'd0);
        check("abort_cout", {31'd0, Cout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("abort_hold_%0d", i), {23'd0, done, Cout, Z}, 32'd0);
        end
        @(negedge clk);
        check("abort_done_after", {31'd0, done}, 32'd1);
        check("abort_product", {24'd0, Cout, Z}, 32'd225);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
